// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: CPU stores fill a TX FIFO, a serializer drains it onto tx.
// Status and control registers are readable combinationally for same-cycle polling.
module uart_tx_mmio #(
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [12:0] BASE_ADDR    = 13'h1F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [12:0] address,
  input  logic [63:0] data_write,
  input  logic        mem_wr,
  output logic [63:0] data_read,
  output logic        tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(CLKS_PER_BIT);

  localparam logic [12:0] ADDR_TXDATA = BASE_ADDR;
  localparam logic [12:0] ADDR_STATUS = BASE_ADDR + 13'd8;
  localparam logic [12:0] ADDR_CTRL   = BASE_ADDR + 13'd16;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e          state_q;
  logic [CW-1:0]   baud_q;
  logic [2:0]      bitcnt_q;
  logic [7:0]      shift_q;
  logic            tx_q;
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic            enable_q;
  logic            ovf_q;
  logic [7:0]      mem_q [FIFO_DEPTH];

  logic            selTx, selStatus, selCtrl;
  logic            full, empty, busy;
  logic            push, pop, clear, baudLast;
  logic [PW-1:0]   count;
  logic            unused_wdata;

  assign unused_wdata = ^data_write[63:8];

  assign selTx     = (address == ADDR_TXDATA);
  assign selStatus = (address == ADDR_STATUS);
  assign selCtrl   = (address == ADDR_CTRL);

  assign count    = wptr_q - rptr_q;
  assign empty    = (wptr_q == rptr_q);
  assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign busy     = (state_q != IDLE);
  assign baudLast = (baud_q == CW'(CLKS_PER_BIT - 1));

  // Clear beats a same-cycle push; pops are judged on pre-edge state only.
  assign clear = mem_wr && selCtrl && data_write[1];
  assign push  = mem_wr && selTx && !full && !clear;
  assign pop   = (state_q == IDLE) && enable_q && !empty;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) wptr_d = wptr_q + PW'(1);
    if (pop)  rptr_d = rptr_q + PW'(1);
    if (clear) begin
      wptr_d = '0;
      rptr_d = '0;
    end
  end

  always_comb begin
    data_read = 64'h0;
    if (selStatus)
      data_read = {51'h0, 5'(count), 4'h0, ovf_q, busy, empty, full};
    else if (selCtrl)
      data_read = {63'h0, enable_q};
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= data_write[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      enable_q <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      if (mem_wr && selCtrl) enable_q <= data_write[0];
      if (mem_wr && selTx && full) ovf_q <= 1'b1;
      else if (mem_wr && selStatus) ovf_q <= 1'b0;
    end
  end

  // Serializer: tx is registered and updated on the same edge as each state change.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bitcnt_q <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            shift_q  <= mem_q[rptr_q[AW-1:0]];
            bitcnt_q <= '0;
            baud_q   <= '0;
            tx_q     <= 1'b0;
            state_q  <= START;
          end
        end
        START: begin
          if (baudLast) begin
            baud_q  <= '0;
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
        DATA: begin
          if (baudLast) begin
            baud_q <= '0;
            if (bitcnt_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              shift_q  <= {1'b0, shift_q[7:1]};
              tx_q     <= shift_q[1];
              bitcnt_q <= bitcnt_q + 3'd1;
            end
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
        STOP: begin
          if (baudLast) begin
            baud_q  <= '0;
            state_q <= IDLE;
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx = tx_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio: register-access vector table plus hand-built
// multi-cycle sequences checking frame waveforms and timing cycle by cycle.
module tb_uart_tx_mmio;

  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam logic [12:0] BASE  = 13'h1F00;
  localparam logic [12:0] A_TX  = BASE;
  localparam logic [12:0] A_ST  = BASE + 13'd8;
  localparam logic [12:0] A_CT  = BASE + 13'd16;

  typedef struct {
    logic [12:0] addr;
    logic [63:0] wdata;
    logic        wr;
    logic [63:0] expRead;
    logic        expTx;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [12:0] address;
  logic [63:0] data_write;
  logic        mem_wr;
  logic [63:0] data_read;
  logic        tx;

  int vecCount  = 0;
  int missCount = 0;
  int cyc       = 0;

  vec_t       vecs [18];
  logic [7:0] expQ [4];
  int         expN;

  uart_tx_mmio #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH),
    .BASE_ADDR   (BASE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .data_write(data_write),
    .mem_wr    (mem_wr),
    .data_read (data_read),
    .tx        (tx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [12:0] a, input logic [63:0] d, input logic w);
    address    = a;
    data_write = d;
    mem_wr     = w;
  endtask

  task automatic checkOutput(input string nm, input logic [63:0] act, input logic [63:0] want);
    vecCount++;
    if (act !== want) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h", nm, act, want);
    end
  endtask

  task automatic waitFall(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i <= budget && !found; i++) begin
      if (tx === 1'b0) found = 1'b1;
      else tick();
    end
  endtask

  // Entered on the first start-bit sample; returns on the last stop-bit sample.
  // Optionally drives one store during sample injK so it lands on the following edge.
  task automatic expectFrame(input logic [7:0] b, input string nm, input int injK,
                             input logic [12:0] injA, input logic [63:0] injD);
    logic [63:0] actPat;
    logic [63:0] wantPat;
    logic        wantBit;
    actPat  = '0;
    wantPat = '0;
    for (int k = 0; k < 40; k++) begin
      if (k < 4)       wantBit = 1'b0;
      else if (k < 36) wantBit = b[3'((k - 4) / 4)];
      else             wantBit = 1'b1;
      actPat[k]  = tx;
      wantPat[k] = wantBit;
      if (k == injK) applyStimulus(injA, injD, 1'b1);
      if (k < 39) begin
        tick();
        applyStimulus(13'h0, 64'h0, 1'b0);
      end
    end
    checkOutput(nm, actPat, wantPat);
  endtask

  task automatic drain(input string nm);
    bit found;
    int prevStart;
    prevStart = 0;
    for (int i = 0; i < expN; i++) begin
      waitFall(12, found);
      checkOutput($sformatf("%s start%0d", nm, i), 64'(found), 64'd1);
      if (i > 0) checkOutput($sformatf("%s period%0d", nm, i), 64'(cyc - prevStart), 64'd41);
      prevStart = cyc;
      expectFrame(expQ[i], $sformatf("%s frame%0d", nm, i), -1, 13'h0, 64'h0);
    end
    waitFall(60, found);
    checkOutput($sformatf("%s no extra frame", nm), 64'(found), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit found;
    int badTx;
    int startA;

    // Register-access vectors; expRead is the pre-edge value for that cycle.
    vecs[0]  = '{A_ST,          64'h0,  1'b0, 64'h2,   1'b1};
    vecs[1]  = '{A_CT,          64'h0,  1'b0, 64'h1,   1'b1};
    vecs[2]  = '{BASE + 13'd24, 64'h0,  1'b0, 64'h0,   1'b1};
    vecs[3]  = '{13'h0,         64'h0,  1'b0, 64'h0,   1'b1};
    vecs[4]  = '{A_TX,          64'h0,  1'b0, 64'h0,   1'b1};
    vecs[5]  = '{A_CT,          64'h0,  1'b1, 64'h1,   1'b1};
    vecs[6]  = '{A_CT,          64'h0,  1'b0, 64'h0,   1'b1};
    vecs[7]  = '{A_TX,          64'h11, 1'b1, 64'h0,   1'b1};
    vecs[8]  = '{A_ST,          64'h0,  1'b0, 64'h100, 1'b1};
    vecs[9]  = '{A_TX,          64'h22, 1'b1, 64'h0,   1'b1};
    vecs[10] = '{A_TX,          64'h33, 1'b1, 64'h0,   1'b1};
    vecs[11] = '{A_TX,          64'h44, 1'b1, 64'h0,   1'b1};
    vecs[12] = '{A_ST,          64'h0,  1'b0, 64'h401, 1'b1};
    vecs[13] = '{A_TX,          64'h55, 1'b1, 64'h0,   1'b1};
    vecs[14] = '{A_ST,          64'h0,  1'b0, 64'h409, 1'b1};
    vecs[15] = '{A_ST,          64'h0,  1'b1, 64'h409, 1'b1};
    vecs[16] = '{A_ST,          64'h0,  1'b0, 64'h401, 1'b1};
    vecs[17] = '{A_CT,          64'h0,  1'b0, 64'h0,   1'b1};

    reset = 1'b1;
    applyStimulus(13'h0, 64'h0, 1'b0);
    tick();
    tick();
    reset = 1'b0;

    badTx = 0;
    for (int i = 0; i < 20; i++) begin
      if (tx !== 1'b1) badTx++;
      tick();
    end
    checkOutput("idle tx high 20 cycles", 64'(badTx), 64'd0);

    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].addr, vecs[i].wdata, vecs[i].wr);
      #1;
      checkOutput($sformatf("vec%0d read", i), data_read, vecs[i].expRead);
      checkOutput($sformatf("vec%0d tx", i), 64'(tx), 64'(vecs[i].expTx));
      tick();
    end
    applyStimulus(13'h0, 64'h0, 1'b0);

    // Enable the held FIFO: four accepted bytes in order, dropped fifth never sent.
    applyStimulus(A_CT, 64'h1, 1'b1);
    tick();
    applyStimulus(13'h0, 64'h0, 1'b0);
    expQ[0] = 8'h11; expQ[1] = 8'h22; expQ[2] = 8'h33; expQ[3] = 8'h44;
    expN = 4;
    drain("enable");
    applyStimulus(A_ST, 64'h0, 1'b0);
    #1;
    checkOutput("status after drain", data_read, 64'h2);

    // Single byte 0xA5: pop one edge after the store, busy drops on IDLE entry.
    applyStimulus(A_TX, 64'hA5, 1'b1);
    tick();
    applyStimulus(A_ST, 64'h0, 1'b0);
    #1;
    checkOutput("A5 tx before pop", 64'(tx), 64'd1);
    checkOutput("A5 status queued", data_read, 64'h100);
    tick();
    checkOutput("A5 status popped", data_read, 64'h6);
    expectFrame(8'hA5, "A5 frame", -1, 13'h0, 64'h0);
    applyStimulus(A_ST, 64'h0, 1'b0);
    #1;
    checkOutput("A5 busy in last stop cycle", data_read, 64'h6);
    tick();
    checkOutput("A5 busy cleared", data_read, 64'h2);

    // Reset during data bit 3 of 0xF0 with a second byte queued.
    applyStimulus(A_TX, 64'hF0, 1'b1);
    tick();
    applyStimulus(A_TX, 64'h0F, 1'b1);
    tick();
    applyStimulus(13'h0, 64'h0, 1'b0);
    repeat (17) tick();
    checkOutput("F0 data bit3 before reset", 64'(tx), 64'd0);
    reset = 1'b1;
    tick();
    applyStimulus(A_ST, 64'h0, 1'b0);
    #1;
    checkOutput("tx after mid-frame reset", 64'(tx), 64'd1);
    checkOutput("status after mid-frame reset", data_read, 64'h2);
    reset = 1'b0;
    waitFall(60, found);
    checkOutput("no activity after reset", 64'(found), 64'd0);

    // CTRL=3 mid-frame with two bytes queued: frame finishes, queue is gone.
    applyStimulus(A_TX, 64'h3C, 1'b1);
    tick();
    applyStimulus(A_TX, 64'h5A, 1'b1);
    tick();
    applyStimulus(A_TX, 64'h96, 1'b1);
    expectFrame(8'h3C, "clear frame", 10, A_CT, 64'h3);
    applyStimulus(A_ST, 64'h0, 1'b0);
    #1;
    checkOutput("clear status", data_read, 64'h6);
    applyStimulus(A_CT, 64'h0, 1'b0);
    #1;
    checkOutput("clear ctrl readback", data_read, 64'h1);
    applyStimulus(13'h0, 64'h0, 1'b0);
    waitFall(60, found);
    checkOutput("no frame after clear", 64'(found), 64'd0);

    // Full FIFO, push on the same edge IDLE pops: push lost, overflow set.
    applyStimulus(A_CT, 64'h0, 1'b1);
    tick();
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(A_TX, 64'(i), 1'b1);
      tick();
    end
    applyStimulus(A_ST, 64'h0, 1'b0);
    #1;
    checkOutput("full before pop", data_read, 64'h401);
    applyStimulus(A_CT, 64'h1, 1'b1);
    tick();
    applyStimulus(A_TX, 64'h77, 1'b1);
    tick();
    applyStimulus(A_ST, 64'h0, 1'b0);
    #1;
    checkOutput("push on pop into full", data_read, 64'h30C);
    expQ[0] = 8'h01; expQ[1] = 8'h02; expQ[2] = 8'h03; expQ[3] = 8'h04;
    expN = 4;
    drain("fullpop");

    // Push into empty FIFO during STOP: next start one cycle after IDLE entry.
    applyStimulus(A_TX, 64'h81, 1'b1);
    tick();
    applyStimulus(13'h0, 64'h0, 1'b0);
    waitFall(3, found);
    checkOutput("stop-push first start", 64'(found), 64'd1);
    startA = cyc;
    expectFrame(8'h81, "stop-push frame0", 37, A_TX, 64'hC3);
    waitFall(12, found);
    checkOutput("stop-push second start", 64'(found), 64'd1);
    checkOutput("stop-push period", 64'(cyc - startA), 64'd41);
    expectFrame(8'hC3, "stop-push frame1", -1, 13'h0, 64'h0);
    waitFall(60, found);
    checkOutput("stop-push no extra frame", 64'(found), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter that responds to the CPU's data-memory bus (address, data_write, mem_wr, data_read) beside the data memory and switch/LED I/O. Stores to its data register queue bytes in a FIFO. A serializer drains the FIFO onto a single 8N1 serial line. Loads return status combinationally, so the single-cycle CPU can poll it with an ordinary LDUR in the same cycle.

## Interface
Parameters:
- CLKS_PER_BIT, 868: clk cycles per serial bit (100 MHz / 115200). Minimum 2.
- FIFO_DEPTH, 8: TX FIFO entries. Power of two, 2..16.
- BASE_ADDR, 13'h1F00: byte address of register 0. Must be 8-byte aligned.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- address  input  13  CPU byte address, same field the CPU feeds to data memory.
- data_write  input  64  CPU store data.
- mem_wr  input  1  store strobe, one cycle per STUR.
- data_read  output  64  combinational read data for the addressed register; 0 when not selected.
- tx  output  1  serial line, registered, idle high.

## Operation
- Register map; all registers are 64-bit at 8-byte spacing. Any other address has no effect and reads 0.
- BASE_ADDR+0, TXDATA, write-only. A store pushes data_write[7:0] into the FIFO if the FIFO is not full. A store to a full FIFO drops the byte and sets the sticky overflow flag. Reads return 0.
- BASE_ADDR+8, STATUS, read. Fields: bit0 full, bit1 empty, bit2 busy (state≠IDLE), bit3 overflow, bits[12:8] entry count, all other bits 0. Any store to STATUS clears overflow.
- BASE_ADDR+16, CTRL, read/write. Fields: bit0 enable (reset 1), bit1 clear. Writing 1 to clear empties the FIFO for that cycle only; clear is self-clearing and always reads 0.
- FIFO:
  - Read and write pointers are log2(FIFO_DEPTH)+1 bits. Full and empty come from the pointer MSB and equality.
  - Full and empty are evaluated before the edge. A push and a pop in the same cycle are both honoured when legal. On a full FIFO, a pop and a push in the same cycle lose the push.
  - A clear in the same cycle as a push: clear wins and the pushed byte is discarded.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: when enable=1 and the FIFO is not empty, pop the head into an 8-bit shift register, zero the bit counter and baud counter, and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx=shift[0]. Every CLKS_PER_BIT cycles, shift right and increment the bit counter. After 8 bits (LSB first), go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- The baud counter counts 0..CLKS_PER_BIT-1 and wraps. It resets to 0 on every state entry.
- Setting enable=0, or clearing the FIFO, mid-frame does not abort the current frame. It only blocks further pops.

## Timing
- Reset values: tx=1, state IDLE, FIFO empty (count 0), overflow=0, enable=1. STATUS therefore reads 64'h2.
- A reset asserted mid-frame forces tx=1 on the next edge and discards the frame and all queued bytes.
- data_read is valid in the same cycle as the address, with zero latency. It reflects register state before the current edge.
- A store is visible in STATUS in the cycle after the mem_wr cycle.
- Push to tx falling edge:
  - Byte stored at edge N on an idle, empty, enabled block.
  - Pop happens at edge N+1; tx goes low after edge N+1.
- Frame duration is exactly 10*CLKS_PER_BIT cycles: start bit, 8 data bits, stop bit.
- Back-to-back bytes: one IDLE cycle between the end of STOP and the next START. Frame period is 10*CLKS_PER_BIT+1 cycles.
- busy rises on the pop edge and falls on the edge that enters IDLE.

## Test plan
Run all scenarios with CLKS_PER_BIT=4 and FIFO_DEPTH=4.
- After reset: STATUS reads 64'h2, CTRL reads 64'h1, tx=1 for 20 cycles, and reads of BASE+24 and of address 0 return 0.
- Store 0xA5 to TXDATA: tx low 2 cycles later and held 4 cycles; then bits 1,0,1,0,0,1,0,1, 4 cycles each; then high 4 cycles. busy clears at cycle 42.
- With CTRL.enable=0, store 5 bytes: STATUS shows count=4, full=1, overflow=1. Store to STATUS: overflow=0. Set enable=1: the 4 accepted bytes are sent in order with a 41-cycle period, and the 5th byte never appears.
- Reset mid-frame during DATA bit 3: tx=1 next cycle, STATUS=64'h2, and no further activity on tx.
- Write CTRL=3 while a frame is in progress with 2 bytes queued: the current frame completes intact, count goes to 0, and no further frames are sent.
- Same-cycle cases:
  - Push into a full FIFO on the cycle IDLE pops: the push is dropped and overflow sets.
  - Push into an empty FIFO while in STOP: the byte starts 1 cycle after IDLE is entered.
